// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with registered reads,
// write-to-read bypass, optional hardwired-zero register and a per-register
// pending-write scoreboard for RAW hazard detection at issue.
// Optional trace output is compiled in when REGFILE_TRACE_EN is defined.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     busy_any
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q;
  logic [Depth-1:0]  busy_d;
  logic              wr_eff;

  logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
  logic [DATA_W-1:0] rd_val    [NUM_RD];
  logic              rd_bsy    [NUM_RD];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_q;

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_eff = wr_en && !(ZERO_REG && (wr_addr == '0));

  // Scoreboard next state: clear on write, then set on reserve so set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_addr_a[k] = rd_addr[k*ADDR_W +: ADDR_W];

    // Bypassed read value; register 0 reads zero even while being written.
    always_comb begin
      if (ZERO_REG && (rd_addr_a[k] == '0)) begin
        rd_val[k] = '0;
      end else if (wr_en && (wr_addr == rd_addr_a[k])) begin
        rd_val[k] = wr_data;
      end else begin
        rd_val[k] = mem_q[rd_addr_a[k]];
      end
      rd_bsy[k] = busy_d[rd_addr_a[k]];
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_data_q[k];
  end

  assign rd_busy  = rd_busy_q;
  assign busy_any = |busy_q;

  // State update: storage, scoreboard and registered read ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        rd_data_q[k] <= '0;
      end
      rd_busy_q <= '0;
    end else begin
      if (wr_eff) begin
        mem_q[wr_addr] <= wr_data;
      end
      busy_q <= busy_d;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        rd_data_q[k] <= rd_val[k];
        rd_busy_q[k] <= rd_bsy[k];
      end
    end
  end

`ifdef REGFILE_TRACE_EN
  // Simulation trace of effective writes and per-port read results.
  always @(posedge clock) begin
    if (!reset) begin
      if (wr_eff) begin
        $display("Write addr=%h value=%h", wr_addr, wr_data);
      end
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        $display("Read port=%0d addr=%h value=%h busy=%b", k, rd_addr_a[k], rd_val[k],
                 rd_bsy[k]);
      end
    end
  end
`else
  // Trace disabled: no display statements are compiled.
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver pushes the expected registered
// response for each cycle; the monitor pops and compares one cycle later.
module tb_regfile_mp;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned NumRd = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [2*AddrW-1:0] rd_addr;
  logic [2*DataW-1:0] rd_data;
  logic [NumRd-1:0]   rd_busy;
  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [DataW-1:0] wr_data;
  logic             rsv_en;
  logic [AddrW-1:0] rsv_addr;
  logic             busy_any;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string      name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        any;
  } exp_t;

  exp_t sb[$];

  regfile_mp #(
    .DATA_W  (DataW),
    .ADDR_W  (AddrW),
    .NUM_RD  (NumRd),
    .ZERO_REG(1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .busy_any(busy_any)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: the DUT presents a registered response every edge after a stimulus.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, "rd_data0", rd_data[31:0], e.d0);
      check(e.name, "rd_data1", rd_data[63:32], e.d1);
      check(e.name, "rd_busy", {30'd0, rd_busy}, {30'd0, e.busy});
      check(e.name, "busy_any", {31'd0, busy_any}, {31'd0, e.any});
    end
  end

  task automatic step(input string nm, input logic rst, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic rs,
                      input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic eany);
    exp_t e;
    @(negedge clock);
    reset    = rst;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = rs;
    rsv_addr = ra;
    rd_addr  = {a1, a0};
    e.name = nm;
    e.d0   = e0;
    e.d1   = e1;
    e.busy = eb;
    e.any  = eany;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;

    //    name        rst we wa     wd            rs ra     a0     a1     e0            e1            busy  any
    step("reset0",    1, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 0);
    step("preload3",  0, 1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    step("rst_apply", 1, 0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        2'b00, 0);
    step("rst_rd3",   0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        2'b00, 0);
    step("wr5",       0, 1, 5'd5,  32'h12345678, 0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 0);
    step("rd5",       0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd5,  5'd5,  32'h12345678, 32'h12345678, 2'b00, 0);
    step("wr7a",      0, 1, 5'd7,  32'h11111111, 0, 5'd0,  5'd5,  5'd3,  32'h12345678, 32'h0,        2'b00, 0);
    step("byp7",      0, 1, 5'd7,  32'h22222222, 0, 5'd0,  5'd7,  5'd7,  32'h22222222, 32'h22222222, 2'b00, 0);
    step("rd7",       0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd0,  32'h22222222, 32'h0,        2'b00, 0);
    step("zero_wr",   0, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 0);
    step("zero_rd",   0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 0);
    step("rsv9",      0, 0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd5,  32'h0,        32'h12345678, 2'b01, 1);
    step("rsv9_rsv",  0, 0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 1);
    step("wr_rsv9",   0, 1, 5'd9,  32'hA5A5A5A5, 1, 5'd9,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11, 1);
    step("wr9",       0, 1, 5'd9,  32'h5A5A5A5A, 0, 5'd0,  5'd9,  5'd9,  32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00, 0);
    step("rsv4_wr5",  0, 1, 5'd5,  32'hCAFEF00D, 1, 5'd4,  5'd4,  5'd5,  32'h0,        32'hCAFEF00D, 2'b01, 1);
    step("rst_mid",   1, 1, 5'd4,  32'hAAAA5555, 1, 5'd4,  5'd4,  5'd5,  32'h0,        32'h0,        2'b00, 0);
    step("post_rst",  0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd4,  5'd5,  32'h0,        32'h0,        2'b00, 0);
    step("rsv10_wr4", 0, 1, 5'd4,  32'h00000001, 1, 5'd10, 5'd10, 5'd4,  32'h0,        32'h00000001, 2'b01, 1);
    step("rsv4_wr10", 0, 1, 5'd10, 32'h00000002, 1, 5'd4,  5'd10, 5'd4,  32'h00000002, 32'h00000001, 2'b10, 1);
    step("final_rd",  0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd4,  32'h00000002, 32'h00000001, 2'b10, 1);

    @(negedge clock);
    wr_en = 1'b0; rsv_en = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath.
- Next generation of the CPU register file: configurable data width, depth and read-port count.
- Adds synchronous reset, registered reads with write-to-read bypass, and a hardwired-zero register.
- Adds a per-register pending-write scoreboard used by the issue stage to detect RAW hazards.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and reserves.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered scoreboard bit of each read address.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  mark a destination register as pending (instruction issued).
- rsv_addr  in  ADDR_W  register to reserve.
- busy_any  out  1  OR of all scoreboard bits, combinational from state.

Behaviour:
- Clock is `clock`; reset is synchronous and active-high, named `reset`.
- Reset, rising edge with reset=1:
  - all registers <= 0;
  - all scoreboard bits <= 0;
  - rd_data <= 0, rd_busy <= 0.
  - Reset overrides wr_en and rsv_en in the same cycle.
  - Reset mid-stream discards any in-flight reservation.
- Write: on a rising edge with wr_en=1, mem[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency is 1 cycle. On each edge, for each port k:
  - rd_data[k] <= bypassed value of rd_addr[k];
  - rd_busy[k] <= next-state busy bit of rd_addr[k].
- Bypass: if wr_en=1 and wr_addr==rd_addr[k] in the same cycle, rd_data[k] gets wr_data, not the old contents.
  - With ZERO_REG=1, address 0 always returns 0, including when bypassing.
- Multiple read ports may use the same address; each returns an identical value.
- Scoreboard, per register:
  - rsv_en=1 sets busy[rsv_addr].
  - wr_en=1 clears busy[wr_addr].
  - Same cycle, same address: set wins, so the register stays busy (the newer instruction owns it).
  - Same cycle, different addresses: both take effect.
  - Reserving an already-busy register leaves it busy (no count).
  - Writing a non-busy register is legal and leaves it clear.
  - ZERO_REG=1: busy[0] is constant 0.
- Address range is the full 2**ADDR_W space; no out-of-range case exists.
- No X propagation: every output is driven from reset onward.

Optional Feature:
- Macro: REGFILE_TRACE_EN.
- Defined:
  - simulation-only $display on every effective write: "Write addr=%h value=%h";
  - on every cycle with reset=0, one line per read port: "Read port=%0d addr=%h value=%h busy=%b".
- Not defined: no display statements are compiled.
- RTL behaviour, timing and ports are identical either way.

Test Plan:
- Reset:
  - pre-load mem[3]=0xDEADBEEF;
  - assert reset for 1 cycle;
  - read addr 3 -> rd_data=0x00000000 one cycle later, rd_busy=0, busy_any=0.
- Write then read:
  - write mem[5]=0x12345678;
  - next cycle set rd_addr[0]=5 -> rd_data[0]=0x12345678 after 1 cycle;
  - port 1 on addr 5 returns the same.
- Bypass:
  - mem[7]=0x11111111;
  - same cycle: wr_en=1, wr_addr=7, wr_data=0x22222222, rd_addr[0]=7;
  - -> rd_data[0]=0x22222222 on the next edge.
- Zero register:
  - write 0xFFFFFFFF to addr 0 and rsv_en on addr 0;
  - -> reads of addr 0 return 0, rd_busy=0, busy_any=0.
- Scoreboard:
  - rsv addr 9 -> rd_busy=1 for addr 9, busy_any=1;
  - later, write addr 9 together with rsv addr 9 -> still busy;
  - next, write addr 9 alone -> rd_busy=0, busy_any=0.
- Reset mid-operation:
  - reserve addr 4 and, in the same cycle as reset, write addr 4 = 0xAAAA5555;
  - -> mem[4]=0, busy[4]=0, all rd_data=0 next cycle.
